// File: rtl/canvas_pkg.sv
// Shared definitions for the canvas sequencer: controller states, default canvas size
// and the 3x3 brush offset table (used only when CANVAS_BRUSH3_EN is defined).
package canvas_pkg;

    localparam int CANVAS_W_DEF = 32;
    localparam int CANVAS_H_DEF = 32;
    localparam int BRUSH_TAPS   = 9;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PAINT,
        RD,
        HOLD
    } canvas_state_e;

    // Row-major walk from (-1,-1) to (+1,+1) around the painted point.
    localparam int BRUSH_DY [BRUSH_TAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
    localparam int BRUSH_DX [BRUSH_TAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/canvas_brush_gen.sv
// Brush cell generator: offsets the painted point by brush tap idx_i and flags cells
// that fall off the canvas. Only built when CANVAS_BRUSH3_EN is defined.
`ifdef CANVAS_BRUSH3_EN
module canvas_brush_gen
    import canvas_pkg::*;
#(
    parameter int CANVAS_W = CANVAS_W_DEF,
    parameter int CANVAS_H = CANVAS_H_DEF,
    localparam int CW = $clog2(CANVAS_W),
    localparam int RW = $clog2(CANVAS_H)
) (
    input  logic [CW-1:0] x_i,
    input  logic [RW-1:0] y_i,
    input  logic [3:0]    idx_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          in_range_o
);

    int col_s;
    int row_s;

    // Signed arithmetic so edge cells go negative instead of wrapping.
    always_comb begin
        col_s      = int'(x_i) + BRUSH_DX[idx_i];
        row_s      = int'(y_i) + BRUSH_DY[idx_i];
        in_range_o = (col_s >= 0) && (col_s < CANVAS_W) && (row_s >= 0) && (row_s < CANVAS_H);
        col_o      = col_s[CW-1:0];
        row_o      = row_s[RW-1:0];
    end

endmodule
`endif

// File: rtl/canvas_seq_ctrl.sv
// Canvas sequencer: arbitrates clear / classify / paint requests, drives the canvas
// row-memory ports and streams rows to the model. CANVAS_BRUSH3_EN selects a 3x3 brush.
module canvas_seq_ctrl
    import canvas_pkg::*;
#(
    parameter int CANVAS_W = CANVAS_W_DEF,
    parameter int CANVAS_H = CANVAS_H_DEF,
    localparam int CW = $clog2(CANVAS_W),
    localparam int RW = $clog2(CANVAS_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    input  logic                classify_req,
    input  logic                paint_req,
    input  logic [CW-1:0]       paint_x,
    input  logic [RW-1:0]       paint_y,
    output logic                paint_ack,
    output logic                wr_en,
    output logic [CW-1:0]       wr_col,
    output logic [RW-1:0]       wr_row,
    output logic                row_clr,
    output logic                rd_en,
    output logic [RW-1:0]       rd_row,
    input  logic [CANVAS_W-1:0] rd_data,
    output logic                m_valid,
    output logic [CANVAS_W-1:0] m_data,
    output logic                m_last,
    input  logic                m_ready,
    output logic                busy,
    output logic                clear_done,
    output logic                stream_done
);

    canvas_state_e       state_q, state_d;
    logic [RW-1:0]       row_cnt_q, row_cnt_d;
    logic [CW-1:0]       pt_x_q, pt_x_d;
    logic [RW-1:0]       pt_y_q, pt_y_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic [CANVAS_W-1:0] m_data_q, m_data_d;
    logic                paint_acc;
    logic                last_row;

`ifdef CANVAS_BRUSH3_EN
    logic [3:0]    brush_q, brush_d;
    logic [CW-1:0] brush_col;
    logic [RW-1:0] brush_row;
    logic          brush_ok;

    canvas_brush_gen #(.CANVAS_W(CANVAS_W), .CANVAS_H(CANVAS_H)) u_brush (
        .x_i       (pt_x_q),
        .y_i       (pt_y_q),
        .idx_i     (brush_q),
        .col_o     (brush_col),
        .row_o     (brush_row),
        .in_range_o(brush_ok)
    );
`endif

    assign last_row    = (row_cnt_q == RW'(CANVAS_H - 1));
    assign busy        = (state_q != IDLE);
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    // The acknowledge is combinational from the request, so it must also drop while in reset.
    assign paint_ack   = paint_acc && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            pt_x_q    <= '0;
            pt_y_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
`ifdef CANVAS_BRUSH3_EN
            brush_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            pt_x_q    <= pt_x_d;
            pt_y_q    <= pt_y_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
`ifdef CANVAS_BRUSH3_EN
            brush_q   <= brush_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        pt_x_d      = pt_x_q;
        pt_y_d      = pt_y_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        paint_acc   = 1'b0;
        wr_en       = 1'b0;
        wr_col      = '0;
        wr_row      = '0;
        row_clr     = 1'b0;
        rd_en       = 1'b0;
        rd_row      = '0;
        clear_done  = 1'b0;
        stream_done = 1'b0;
`ifdef CANVAS_BRUSH3_EN
        brush_d     = brush_q;
`endif
        unique case (state_q)
            IDLE: begin
                row_cnt_d = '0;
                if (clear_req) begin
                    state_d = CLEAR;
                end else if (classify_req) begin
                    state_d = RD;
                end else if (paint_req) begin
                    paint_acc = 1'b1;
                    pt_x_d    = paint_x;
                    pt_y_d    = paint_y;
                    state_d   = PAINT;
                end
            end
            CLEAR: begin
                row_clr = 1'b1;
                wr_row  = row_cnt_q;
                if (last_row) begin
                    clear_done = 1'b1;
                    row_cnt_d  = '0;
                    state_d    = IDLE;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            PAINT: begin
`ifdef CANVAS_BRUSH3_EN
                // Off-canvas taps still take their cycle, just without a write.
                wr_en  = brush_ok;
                wr_col = brush_ok ? brush_col : '0;
                wr_row = brush_ok ? brush_row : '0;
                if (brush_q == 4'(BRUSH_TAPS - 1)) begin
                    brush_d = '0;
                    state_d = IDLE;
                end else begin
                    brush_d = brush_q + 1'b1;
                end
`else
                wr_en   = 1'b1;
                wr_col  = pt_x_q;
                wr_row  = pt_y_q;
                state_d = IDLE;
`endif
            end
            RD: begin
                rd_en   = 1'b1;
                rd_row  = row_cnt_q;
                state_d = HOLD;
            end
            HOLD: begin
                // m_valid is always low on entry, so it doubles as the first-cycle marker.
                if (!m_valid_q) begin
                    m_data_d  = rd_data;
                    m_valid_d = 1'b1;
                    m_last_d  = last_row;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        stream_done = 1'b1;
                        row_cnt_d   = '0;
                        state_d     = IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        state_d   = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_canvas_seq_ctrl.sv
// Scoreboard bench for canvas_seq_ctrl: a canvas-level reference model predicts writes,
// streamed rows and pulse counts; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_canvas_seq_ctrl;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int CW = 5;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_req = 1'b0, classify_req = 1'b0, paint_req = 1'b0;
    logic [CW-1:0] paint_x = '0;
    logic [RW-1:0] paint_y = '0;
    logic          paint_ack, wr_en, row_clr, rd_en, m_valid, m_last, busy;
    logic          clear_done, stream_done;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] wr_row, rd_row;
    logic [W-1:0]  rd_data = '0;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    canvas_seq_ctrl #(.CANVAS_W(W), .CANVAS_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .clear_req(clear_req), .classify_req(classify_req), .paint_req(paint_req),
        .paint_x(paint_x), .paint_y(paint_y), .paint_ack(paint_ack),
        .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .row_clr(row_clr),
        .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .clear_done(clear_done), .stream_done(stream_done)
    );

    // Canvas memory seen by the DUT, and the bench's own idea of the canvas.
    logic [W-1:0] ram   [H];
    logic [W-1:0] model [H];

    always @(posedge clk) begin
        if (wr_en)   ram[wr_row][wr_col] <= 1'b1;
        if (row_clr) ram[wr_row] <= '0;
        if (rd_en)   rd_data <= ram[rd_row];
    end

    typedef struct { bit clr; int row; int col; } wr_t;
    typedef struct { logic [W-1:0] data; bit last; } row_t;
    wr_t  exp_wr  [$];
    row_t exp_row [$];

    int checks = 0, failures = 0;
    int act_ack = 0, act_cdone = 0, act_sdone = 0;
    int exp_ack = 0, exp_cdone = 0, exp_sdone = 0;
    int rows_seen = 0;
    bit stall_arm = 0, stall_done = 0;
    int stall_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    wr_t          mon_w;
    row_t         mon_r;
    logic         prev_v = 1'b0, prev_r = 1'b0;
    logic [W-1:0] prev_d = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en && row_clr) check("wr_rowclr_exclusive", 1, 0);
            if (wr_en || row_clr) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", {wr_en, row_clr, wr_row, wr_col}, 0);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_kind_rowclr", row_clr, mon_w.clr);
                    check("wr_row", wr_row, mon_w.row);
                    if (!mon_w.clr) check("wr_col", wr_col, mon_w.col);
                end
            end
            if (prev_v && !prev_r) begin
                check("m_valid_held", m_valid, 1);
                check("m_data_held", m_data, prev_d);
            end
            if (m_valid && m_ready) begin
                if (exp_row.size() == 0) begin
                    check("unexpected_row", m_data, 0);
                end else begin
                    mon_r = exp_row.pop_front();
                    check("m_data", m_data, mon_r.data);
                    check("m_last", m_last, mon_r.last);
                end
                rows_seen++;
            end
            if (paint_ack)   act_ack++;
            if (clear_done)  act_cdone++;
            if (stream_done) act_sdone++;
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
        end else begin
            prev_v = 1'b0;
        end
    end

    // Model ready: random, with an optional forced 5-cycle stall on row 3.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_arm && !stall_done && rows_seen == 3 && m_valid) begin
                stall_left = 5;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic predict(input bit c, input bit k, input bit p, input int x, input int y);
        if (c) begin
            for (int r = 0; r < H; r++) begin
                exp_wr.push_back('{clr: 1'b1, row: r, col: 0});
                model[r] = '0;
            end
            exp_cdone++;
        end else if (k) begin
            rows_seen = 0;
            for (int r = 0; r < H; r++) exp_row.push_back('{data: model[r], last: (r == H - 1)});
            exp_sdone++;
        end else if (p) begin
            exp_ack++;
`ifdef CANVAS_BRUSH3_EN
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                    if (y + dy >= 0 && y + dy < H && x + dx >= 0 && x + dx < W) begin
                        exp_wr.push_back('{clr: 1'b0, row: y + dy, col: x + dx});
                        model[y + dy][x + dx] = 1'b1;
                    end
`else
            exp_wr.push_back('{clr: 1'b0, row: y, col: x});
            model[y][x] = 1'b1;
`endif
        end
    endtask

    task automatic issue(input bit c, input bit k, input bit p, input int x, input int y, input bit stray);
        @(posedge clk); #1;
        clear_req = c; classify_req = k; paint_req = p;
        paint_x = x[CW-1:0]; paint_y = y[RW-1:0];
        predict(c, k, p, x, y);
        @(posedge clk); #1;
        clear_req = 0; classify_req = 0; paint_req = 0;
        if (stray && busy) begin
            clear_req = 1'($urandom); classify_req = 1'($urandom); paint_req = 1;
            @(posedge clk); #1;
            clear_req = 0; classify_req = 0; paint_req = 0;
        end
    endtask

    task automatic wait_idle_and_count(input string what);
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({what, "_idle"}, busy, 0);
        check({what, "_paint_ack_cnt"}, act_ack, exp_ack);
        check({what, "_clear_done_cnt"}, act_cdone, exp_cdone);
        check({what, "_stream_done_cnt"}, act_sdone, exp_sdone);
    endtask

    task automatic run_op(input string what, input bit c, input bit k, input bit p,
                          input int x, input int y, input bit stray);
        issue(c, k, p, x, y, stray);
        wait_idle_and_count(what);
        $display("op %s clr=%0d cls=%0d pnt=%0d x=%0d y=%0d checks=%0d", what, c, k, p, x, y, checks);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int r = 0; r < H; r++) begin
            ram[r]   = $urandom;
            model[r] = ram[r];
        end
        // Reset with a paint request pending: nothing may leak out.
        paint_req = 1;
        #12;
        check("reset_outputs_zero", {paint_ack, wr_en, wr_col, wr_row, row_clr, rd_en, rd_row,
              m_valid, m_data, m_last, busy, clear_done, stream_done}, 0);
        paint_req = 0;
        @(negedge clk); rst_n = 1;

`ifdef CANVAS_BRUSH3_EN
        issue(0, 0, 1, 0, 0, 0);
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("brush_paint_cycles", n, 9);
        check("brush_queue_drained", exp_wr.size(), 0);
        $display("op brush_corner x=0 y=0 cycles=%0d", n);
`else
        @(posedge clk); #1;
        paint_req = 1; paint_x = 5; paint_y = 7;
        predict(0, 0, 1, 5, 7);
        @(negedge clk);
        check("t0_paint_ack", paint_ack, 1);
        check("t0_busy", busy, 0);
        @(posedge clk); #1;
        paint_req = 0;
        @(negedge clk);
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_col", wr_col, 5);
        check("t1_wr_row", wr_row, 7);
        @(negedge clk);
        check("t2_busy", busy, 0);
        $display("op paint_directed x=5 y=7 checks=%0d", checks);
`endif
        wait_idle_and_count("paint_directed");

        run_op("all_three_clear_wins", 1, 1, 1, 3, 3, 0);

        for (int i = 0; i < 10; i++)
            run_op("seed_paint", 0, 0, 1, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 1);

        stall_arm = 1;
        run_op("classify_stall_row3", 0, 1, 0, 0, 0, 1);
        check("stall_applied", stall_done, 1);
        stall_arm = 0;

        for (int i = 0; i < 40; i++) begin
            bit c, k, p;
            c = ($urandom_range(0, 7) == 0);
            k = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 1) == 1);
            if (!c && !k && !p) p = 1;
            run_op("random", c, k, p, $urandom_range(0, W - 1), $urandom_range(0, H - 1), 1);
        end

        // Reset in the middle of a clear: rows 0..9 get wiped, the rest survive.
        @(posedge clk); #1;
        clear_req = 1;
        for (int r = 0; r < H; r++) exp_wr.push_back('{clr: 1'b1, row: r, col: 0});
        @(posedge clk); #1;
        clear_req = 0;
        n = 0;
        while (!(row_clr && wr_row == 10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_row10", wr_row, 10);
        #2 rst_n = 0;
        #1;
        check("midclear_rst_outputs_zero", {paint_ack, wr_en, wr_col, wr_row, row_clr, rd_en, rd_row,
              m_valid, m_data, m_last, busy, clear_done, stream_done}, 0);
        exp_wr.delete();
        for (int r = 0; r < 10; r++) model[r] = '0;
        repeat (2) @(negedge clk);
        check("midclear_rst_busy_held_low", busy, 0);
        rst_n = 1;
        check("midclear_no_clear_done", act_cdone, exp_cdone);
        $display("op reset_mid_clear row=10 checks=%0d", checks);

        run_op("classify_after_abort", 0, 1, 0, 0, 0, 0);

        check("write_queue_empty", exp_wr.size(), 0);
        check("row_queue_empty", exp_row.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/canvas_seq_ctrl.md
CANVAS_SEQ_CTRL -- requirements
Module: canvas_seq_ctrl

Interface
REQ-001 SHALL have parameter CANVAS_W, default 32, canvas columns (power of 2, 4..64).
REQ-002 SHALL have parameter CANVAS_H, default 32, canvas rows (power of 2, 4..64); CW=$clog2(CANVAS_W), RW=$clog2(CANVAS_H).
REQ-003 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-004 SHALL have ports: clear_req in 1 wipe canvas; classify_req in 1 stream canvas to model; paint_req in 1 paint cell; paint_x in CW column; paint_y in RW row.
REQ-005 SHALL have outputs: paint_ack out 1 paint accepted; wr_en out 1 cell write; wr_col out CW; wr_row out RW; row_clr out 1 zero the whole row wr_row.
REQ-006 SHALL have ports: rd_en out 1 row read; rd_row out RW; rd_data in CANVAS_W row bits, valid 1 cycle after rd_en.
REQ-007 SHALL have outputs m_valid out 1, m_data out CANVAS_W, m_last out 1; input m_ready in 1 (model row stream).
REQ-008 SHALL have outputs busy out 1 (state != IDLE); clear_done out 1 pulse; stream_done out 1 pulse.

Function
REQ-009 SHALL implement FSM states IDLE, CLEAR, PAINT, RD, HOLD.
REQ-010 SHALL sample requests only in IDLE; priority clear_req > classify_req > paint_req; lower requests ignored, not queued.
REQ-011 SHALL on paint accept: pulse paint_ack that cycle, latch paint_x/paint_y, enter PAINT next cycle.
REQ-012 SHALL in PAINT assert wr_en with wr_col/wr_row = latched point for 1 cycle, then IDLE.
REQ-013 SHALL on clear accept enter CLEAR: row_clr=1, wr_row=0..CANVAS_H-1, one row per cycle; after last row pulse clear_done and return IDLE (CANVAS_H cycles busy).
REQ-014 SHALL on classify accept enter RD with row counter 0; RD asserts rd_en, rd_row=counter for 1 cycle, then HOLD.
REQ-015 SHALL in first HOLD cycle load m_data<=rd_data, m_valid<=1; m_last=1 iff counter==CANVAS_H-1.
REQ-016 SHALL hold m_valid/m_data/m_last stable until m_valid&&m_ready; on handshake clear m_valid, increment counter, return to RD, or after last row pulse stream_done and go IDLE.
REQ-017 SHALL tolerate unbounded m_ready low; no write (wr_en, row_clr) during RD/HOLD, so streamed rows are a consistent snapshot.
REQ-018 SHALL keep wr_en, row_clr, rd_en, paint_ack, pulses 0 outside their states; wr_en and row_clr never both 1.

Reset
REQ-019 SHALL on rst_n low immediately force IDLE, counters 0, all outputs 0, latched point 0, including mid-CLEAR/PAINT/stream; partial operations are not resumed.
REQ-020 SHALL resume request sampling the first clk edge after rst_n deasserts.

Configuration
REQ-021 SHALL with CANVAS_BRUSH3_EN defined make PAINT 9 cycles, offsets (dy,dx) row-major from (-1,-1) to (+1,+1); out-of-range cells consume the cycle with wr_en=0 (no wrap).
REQ-022 SHALL without CANVAS_BRUSH3_EN use the single-cycle PAINT of REQ-012, no brush counter.

Structure
REQ-023 SHALL put FSM state enum, default dimensions and brush offset table in package canvas_pkg.
REQ-024 SHALL implement the brush offset/bounds logic as sub-module canvas_brush_gen (compiled only with CANVAS_BRUSH3_EN).

Verification
REQ-025 SHALL cover: reset, paint_req (x=5,y=7) -> paint_ack cycle 0, wr_en col 5 row 7 cycle 1, busy low cycle 2.
REQ-026 SHALL cover: clear_req, classify_req, paint_req same cycle -> CLEAR only, 32 row_clr cycles rows 0..31, clear_done once, paint_ack never.
REQ-027 SHALL cover: classify with m_ready stalled 5 cycles on row 3 -> m_data constant, 32 rows in order, m_last only on row 31, stream_done once, no wr_en.
REQ-028 SHALL cover: rst_n low during CLEAR row 10 -> all outputs 0 asynchronously, busy low, no clear_done.
REQ-029 SHALL cover (CANVAS_BRUSH3_EN): paint (0,0) -> 9 PAINT cycles, wr_en only for (0,0),(1,0),(0,1),(1,1).
